led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 13 +
 rtl/led_step_timer.sv | 45 ++++
 rtl/led_seq_ctrl.sv | 65 ++++++
 tb/tb_led_seq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state codes, mode constants and LED pattern helper.
package led_seq_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic MODE_CHASE = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  localparam int N_LED = 8;
  localparam logic [7:0] PAT = 8'h80;
  function automatic logic [7:0] led_pat(input logic mode, input logic [2:0] pos);
    return (mode == MODE_FILL) ? ~(~PAT >> pos) : PAT >> pos;
  endfunction
endpackage

// File: rtl/led_step_timer.sv
// led_step_timer: prescaler, step position and pass counter for one LED run.
module led_step_timer
  import led_seq_pkg::*;
#(
  parameter int SPD_W = 2
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             start,
  input  logic             run,
  input  logic [SPD_W-1:0] speed,
  input  logic [3:0]       reps,
  output logic             tick,
  output logic             pass_end,
  output logic             last_pass,
  output logic [2:0]       pos_n
);
  logic [SPD_W-1:0] spd, psc;
  logic [3:0] rep_max, rep_cnt;
  logic [2:0] pos;
  assign tick = psc == spd;
  assign pass_end = pos == 3'd7;
  assign last_pass = rep_cnt == rep_max;
  assign pos_n = start ? 3'd0 : (run && tick) ? pos + 3'd1 : pos;
  // speed and reps are captured at grant so later input changes cannot disturb a run
  always_ff @(posedge ck) begin
    if (rs) begin
      spd <= '0;
      psc <= '0;
      pos <= '0;
      rep_max <= '0;
      rep_cnt <= '0;
    end else if (start) begin
      spd <= speed;
      psc <= '0;
      pos <= '0;
      rep_max <= (reps == 4'd0) ? 4'd0 : reps - 4'd1;
      rep_cnt <= '0;
    end else if (run) begin
      psc <= tick ? '0 : psc + 1'b1;
      pos <= pos_n;
      if (tick && pass_end) rep_cnt <= rep_cnt + 4'd1;
    end
  end
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: arbitrates chase/fill requests and sequences the LED bar.
module led_seq_ctrl #(
  parameter int SPD_W = 2,
  parameter int N_LED = 8
) (
  input  logic             ck,
  input  logic             rs,
  input  logic [1:0]       req,
  input  logic             abort,
  input  logic [SPD_W-1:0] speed,
  input  logic [3:0]       reps,
  output logic [N_LED-1:0] y,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic [1:0]       st
);
  import led_seq_pkg::*;
  logic [1:0] st_n;
  logic mode, mode_n, last, start, run, tick, pass_end, last_pass;
  logic [2:0] pos_n;
  logic [N_LED-1:0] y_n;
  led_step_timer #(.SPD_W(SPD_W)) u_timer (
    .ck(ck),
    .rs(rs),
    .start(start),
    .run(run),
    .speed(speed),
    .reps(reps),
    .tick(tick),
    .pass_end(pass_end),
    .last_pass(last_pass),
    .pos_n(pos_n)
  );
  // on a double request the side not granted last wins
  always_comb begin
    st_n = ST_IDLE;
    mode_n = mode;
    start = 1'b0;
    if (st == ST_IDLE && req != 2'b00) begin
      st_n = ST_RUN;
      mode_n = (req == 2'b11) ? ~last : req[1];
      start = 1'b1;
    end else if (st == ST_RUN)
      st_n = abort ? ST_IDLE : (tick && pass_end && last_pass) ? ST_DONE : ST_RUN;
  end
  assign run = (st == ST_RUN) && !abort;
  assign y_n = (st_n == ST_RUN) ? led_pat(mode_n, pos_n) : '0;
  always_ff @(posedge ck) begin
    if (rs) begin
      st <= ST_IDLE;
      mode <= MODE_CHASE;
      last <= 1'b1;
      y <= '0;
    end else begin
      st <= st_n;
      mode <= mode_n;
      y <= y_n;
      if (start) last <= mode_n;
    end
  end
  assign busy = st == ST_RUN;
  assign grant = busy ? {mode, ~mode} : 2'b00;
  assign done = st == ST_DONE;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed stimulus with an elapsed-cycle reference model checked every cycle.
module tb_led_seq_ctrl;
  logic ck = 1'b0;
  logic rs, abort;
  logic [1:0] req, speed;
  logic [3:0] reps;
  logic [7:0] y;
  logic [1:0] grant, st;
  logic busy, done;
  int tests = 0, fails = 0;
  bit en = 1'b0;
  int m_st = 0, m_k = 0, m_len = 0, m_spd = 0;
  bit m_mode = 1'b0, m_last = 1'b1;

  led_seq_ctrl #(.SPD_W(2), .N_LED(8)) dut (
    .ck(ck), .rs(rs), .req(req), .abort(abort), .speed(speed), .reps(reps),
    .y(y), .grant(grant), .busy(busy), .done(done), .st(st)
  );

  always #5 ck = ~ck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge ck);
  endtask

  function automatic logic [7:0] model_y();
    int step;
    if (m_st != 1) return 8'h00;
    step = (m_k / (m_spd + 1)) % 8;
    return m_mode ? 8'((255 << (7 - step)) & 255) : 8'(128 >> step);
  endfunction

  // Reference: a run is just an elapsed-cycle count against its total length
  always @(posedge ck) begin
    if (rs) begin
      m_st <= 0;
      m_last <= 1'b1;
    end else if (m_st == 0) begin
      if (req != 2'b00) begin
        m_mode <= (req == 2'b11) ? !m_last : req[1];
        m_last <= (req == 2'b11) ? !m_last : req[1];
        m_st <= 1;
        m_k <= 0;
        m_spd <= int'(speed);
        m_len <= 8 * (int'(speed) + 1) * ((reps == 4'd0) ? 1 : int'(reps));
      end
    end else if (m_st == 1) begin
      if (abort) m_st <= 0;
      else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_len) m_st <= 2;
      end
    end else m_st <= 0;
  end

  always @(negedge ck) begin
    if (en) begin
      chk("st", 32'(st), 32'(m_st));
      chk("y", 32'(y), 32'(model_y()));
      chk("grant", 32'(grant), (m_st == 1) ? (m_mode ? 32'd2 : 32'd1) : 32'd0);
      chk("busy", 32'(busy), 32'(m_st == 1));
      chk("done", 32'(done), 32'(m_st == 2));
    end
  end

  initial begin
    logic [7:0] chase_exp [8];
    logic [7:0] ys[$];
    logic [1:0] gs[$];
    int ts[$];
    int nb, nd, n;
    bit pb;
    chase_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rs = 1'b1; req = 2'b11; abort = 1'b0; speed = 2'd0; reps = 4'd1;
    @(posedge ck);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_st", 32'(st), 0);
      chk("rst_y", 32'(y), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy_done", {busy, done}, 0);
    end
    rs = 1'b0; req = 2'b00;
    cyc();
    // chase, speed 0, one pass
    req = 2'b01;
    cyc();
    chk("chase_grant", 32'(grant), 1);
    req = 2'b00;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      chk("chase_y", 32'(y), 32'(chase_exp[i]));
    end
    cyc();
    chk("chase_done", {st, done}, {2'b10, 1'b1});
    cyc();
    chk("chase_idle", {st, done}, 0);
    // fill, speed 1, two passes; mid-run input changes must be ignored
    req = 2'b10; speed = 2'd1; reps = 4'd2; nb = 0; nd = 0;
    for (int i = 1; i <= 36; i++) begin
      cyc();
      if (i == 1) req = 2'b00;
      if (i == 5) begin speed = 2'd3; reps = 4'd5; end
      if (busy) begin nb++; ys.push_back(y); end
      if (done) nd++;
    end
    chk("fill_busy_len", nb, 32);
    chk("fill_done_cnt", nd, 1);
    chk("fill_y0", 32'(ys[0]), 32'h80);
    chk("fill_y3", 32'(ys[3]), 32'hC0);
    chk("fill_y15", 32'(ys[15]), 32'hFF);
    chk("fill_y16", 32'(ys[16]), 32'h80);
    chk("fill_y31", 32'(ys[31]), 32'hFF);
    // held double request alternates owners
    req = 2'b11; speed = 2'd0; reps = 4'd1; pb = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (busy && !pb) begin gs.push_back(grant); ts.push_back(i); end
      pb = busy;
    end
    req = 2'b00;
    chk("rr_count", gs.size(), 3);
    chk("rr_g0", 32'(gs[0]), 1);
    chk("rr_g1", 32'(gs[1]), 2);
    chk("rr_g2", 32'(gs[2]), 1);
    chk("rr_gap0", ts[1] - ts[0], 10);
    chk("rr_gap1", ts[2] - ts[1], 10);
    cyc();
    // abort mid chase
    req = 2'b01;
    cyc();
    req = 2'b00; n = 0;
    while (y !== 8'h10 && n < 20) begin cyc(); n++; end
    chk("abort_reach", 32'(y), 32'h10);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_st", 32'(st), 0);
    chk("abort_y", 32'(y), 0);
    nd = 0;
    for (int i = 0; i < 3; i++) begin cyc(); if (done) nd++; end
    chk("abort_no_done", nd, 0);
    // pointer now on chase, so fill wins; reps 0 behaves like 1
    req = 2'b11; reps = 4'd0;
    cyc();
    req = 2'b00;
    chk("abort_ptr_grant", 32'(grant), 2);
    nb = 1;
    for (int i = 0; i < 12; i++) begin cyc(); if (busy) nb++; end
    chk("reps0_len", nb, 8);
    // abort coinciding with the final step
    req = 2'b01; reps = 4'd1;
    cyc();
    req = 2'b00; n = 0;
    while (y !== 8'h01 && n < 20) begin cyc(); n++; end
    chk("abort_last_reach", 32'(y), 32'h01);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_last_st", 32'(st), 0);
    chk("abort_last_done", 32'(done), 0);
    cyc();
    chk("abort_last_done2", 32'(done), 0);
    // reset mid fill run
    req = 2'b10; speed = 2'd1;
    cyc();
    req = 2'b00; n = 0;
    while (y !== 8'hF0 && n < 40) begin cyc(); n++; end
    chk("rst_run_reach", 32'(y), 32'hF0);
    rs = 1'b1;
    cyc();
    rs = 1'b0;
    chk("rst_run_outs", {st, y, grant, busy, done}, 0);
    req = 2'b11;
    cyc();
    req = 2'b00;
    chk("rst_ptr_grant", 32'(grant), 1);
    for (int i = 0; i < 20; i++) cyc();
    chk("final_idle", 32'(st), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
